// File: rtl/turf_event_ctrl_mport.sv
// TURF event control port: parses command words from one UDP packet,
// drives the event-output configuration and returns one response packet.
module turf_event_ctrl_mport #(
    parameter int NUM_CHAN         = 4,
    parameter int MAX_CMDS         = 8,
    parameter int MAX_FRAGMENT_LEN = 8095,
    parameter int MAX_ADDR         = 4095,
    parameter int MAX_FRAGSRCMASK  = 6,
    parameter int HOLDOFF_CYCLES   = 31
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [63:0]              s_udphdr_tdata,
    input  logic                     s_udphdr_tvalid,
    output logic                     s_udphdr_tready,
    input  logic [63:0]              s_udpdata_tdata,
    input  logic [7:0]               s_udpdata_tkeep,
    input  logic                     s_udpdata_tlast,
    input  logic                     s_udpdata_tvalid,
    output logic                     s_udpdata_tready,
    output logic [63:0]              m_udphdr_tdata,
    output logic                     m_udphdr_tvalid,
    input  logic                     m_udphdr_tready,
    output logic [63:0]              m_udpdata_tdata,
    output logic [7:0]               m_udpdata_tkeep,
    output logic                     m_udpdata_tlast,
    output logic                     m_udpdata_tvalid,
    input  logic                     m_udpdata_tready,
    input  logic [47:0]              my_mac_address,
    output logic [9:0]               nfragment_count_o,
    output logic [15:0]              fragsrc_mask_o,
    output logic [32*NUM_CHAN-1:0]   event_ip_o,
    output logic [16*NUM_CHAN-1:0]   event_port_o,
    output logic [NUM_CHAN-1:0]      event_open_o
);

    localparam int CW = $clog2(MAX_CMDS + 1);
    localparam logic [15:0] MASKBITS = 16'((1 << MAX_FRAGSRCMASK) - 1);
    localparam logic [7:0] OP_O = 8'h4F;
    localparam logic [7:0] OP_C = 8'h43;
    localparam logic [7:0] OP_I = 8'h49;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_S = 8'h53;

    typedef enum logic [2:0] {
        IDLE, READ, EXEC, HOLD, NEXT, DUMP, WHDR, WPAY
    } state_t;

    state_t              st_q, st_d;
    logic [31:0]         sip_q, sip_d;
    logic [15:0]         sport_q, sport_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [63:0]         word_q, word_d;
    logic                kok_q, kok_d;
    logic                last_q, last_d;
    logic [7:0]          hold_q, hold_d;
    logic [63:0]         buf_q [MAX_CMDS];
    logic [31:0]         ip_q [NUM_CHAN];
    logic [31:0]         ip_d [NUM_CHAN];
    logic [15:0]         port_q [NUM_CHAN];
    logic [15:0]         port_d [NUM_CHAN];
    logic [NUM_CHAN-1:0] open_q, open_d;
    logic [9:0]          nfrag_q, nfrag_d;
    logic [15:0]         mask_q, mask_d;

    logic [7:0]  op;
    logic [7:0]  ch;
    logic [47:0] pl;
    logic        is_oc;
    logic        known;
    logic        is_err;
    logic [9:0]  nf_w;
    logic [15:0] mk_w;
    logic [63:0] resp;
    logic [63:0] rd;
    logic        unused_hdr_len;

    assign op = word_q[7:0];
    assign ch = word_q[15:8];
    assign pl = word_q[63:16];
    assign unused_hdr_len = ^s_udphdr_tdata[15:0];

    assign is_oc  = (op == OP_O) || (op == OP_C);
    assign known  = is_oc || (op == OP_I) || (op == OP_R) ||
                    (op == OP_W) || (op == OP_S);
    assign is_err = !kok_q || !known || (is_oc && ch >= 8'(NUM_CHAN));

    // Command decode: response word and configuration effect of the held word.
    always_comb begin
        open_d  = open_q;
        ip_d    = ip_q;
        port_d  = port_q;
        nfrag_d = nfrag_q;
        mask_d  = mask_q;
        nf_w    = nfrag_q;
        mk_w    = mask_q;
        resp    = word_q;
        if (open_q == '0) begin
            mk_w = 16'(pl[MAX_FRAGSRCMASK-1:0]);
            if (pl[47:32] <= 16'(MAX_FRAGMENT_LEN)) begin
                nf_w = pl[44:35];
            end
        end
        if (is_err) begin
            resp = {word_q[63:8], 8'h3F};
        end else begin
            case (op)
                OP_I: resp = {word_q[15:0], my_mac_address};
                OP_R: resp = {word_q[15:0], 16'(MAX_FRAGMENT_LEN),
                              16'(MAX_ADDR), MASKBITS};
                OP_W: resp = {word_q[15:0], 16'({nf_w, 3'b000}),
                              16'(MAX_ADDR), mk_w};
                OP_S: resp = {word_q[15:0], 32'h0, 16'(open_q)};
                default: resp = word_q;
            endcase
        end
        if (st_q == EXEC && !is_err) begin
            if (op == OP_W) begin
                nfrag_d = nf_w;
                mask_d  = mk_w;
            end
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (ch == 8'(c)) begin
                    if (op == OP_O) begin
                        open_d[c] = 1'b1;
                        ip_d[c]   = pl[47:16];
                        port_d[c] = pl[15:0];
                    end
                    if (op == OP_C) begin
                        open_d[c] = 1'b0;
                    end
                end
            end
        end
    end

    // Next-state logic for the packet sequencer.
    always_comb begin
        st_d    = st_q;
        sip_d   = sip_q;
        sport_d = sport_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        kok_d   = kok_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (st_q)
            IDLE: if (s_udphdr_tvalid && s_udphdr_tready) begin
                sip_d   = s_udphdr_tdata[63:32];
                sport_d = s_udphdr_tdata[31:16];
                cnt_d   = '0;
                st_d    = READ;
            end
            READ: if (s_udpdata_tvalid && s_udpdata_tready) begin
                word_d = s_udpdata_tdata;
                kok_d  = (s_udpdata_tkeep == 8'hFF);
                last_d = s_udpdata_tlast;
                cnt_d  = cnt_q + CW'(1);
                st_d   = EXEC;
            end
            EXEC: begin
                if (is_oc) begin
                    hold_d = 8'(HOLDOFF_CYCLES);
                    st_d   = HOLD;
                end else begin
                    st_d = NEXT;
                end
            end
            HOLD: begin
                if (hold_q == 8'd0) begin
                    st_d = NEXT;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            NEXT: begin
                if (last_q) begin
                    st_d = WHDR;
                end else if (cnt_q == CW'(MAX_CMDS)) begin
                    st_d = DUMP;
                end else begin
                    st_d = READ;
                end
            end
            DUMP: if (s_udpdata_tvalid && s_udpdata_tlast) begin
                st_d = WHDR;
            end
            WHDR: if (m_udphdr_tready) begin
                ptr_d = '0;
                st_d  = WPAY;
            end
            WPAY: if (m_udpdata_tready) begin
                if (m_udpdata_tlast) begin
                    st_d = IDLE;
                end else begin
                    ptr_d = ptr_q + CW'(1);
                end
            end
        endcase
    end

    // Sequencer and command registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st_q    <= IDLE;
            sip_q   <= '0;
            sport_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            word_q  <= '0;
            kok_q   <= 1'b0;
            last_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            st_q    <= st_d;
            sip_q   <= sip_d;
            sport_q <= sport_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            kok_q   <= kok_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Event-path configuration and response buffer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            open_q  <= '0;
            nfrag_q <= 10'd127;
            mask_q  <= '0;
            for (int c = 0; c < NUM_CHAN; c++) begin
                ip_q[c]   <= '0;
                port_q[c] <= '0;
            end
            for (int i = 0; i < MAX_CMDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            open_q  <= open_d;
            nfrag_q <= nfrag_d;
            mask_q  <= mask_d;
            ip_q    <= ip_d;
            port_q  <= port_d;
            for (int i = 0; i < MAX_CMDS; i++) begin
                if (st_q == EXEC && CW'(i) == cnt_q - CW'(1)) begin
                    buf_q[i] <= resp;
                end
            end
        end
    end

    // Response buffer read port and flattened channel outputs.
    always_comb begin
        rd           = '0;
        event_ip_o   = '0;
        event_port_o = '0;
        for (int i = 0; i < MAX_CMDS; i++) begin
            if (CW'(i) == ptr_q) begin
                rd = buf_q[i];
            end
        end
        for (int c = 0; c < NUM_CHAN; c++) begin
            event_ip_o[32*c +: 32]   = ip_q[c];
            event_port_o[16*c +: 16] = port_q[c];
        end
    end

    assign s_udphdr_tready   = aresetn && (st_q == IDLE);
    assign s_udpdata_tready  = aresetn && (st_q == READ || st_q == DUMP);
    assign m_udphdr_tvalid   = (st_q == WHDR);
    assign m_udphdr_tdata    = {sip_q, sport_q,
                                16'({cnt_q, 3'b000}) + 16'd8};
    assign m_udpdata_tvalid  = (st_q == WPAY);
    assign m_udpdata_tdata   = rd;
    assign m_udpdata_tkeep   = 8'hFF;
    assign m_udpdata_tlast   = (ptr_q == cnt_q - CW'(1));
    assign nfragment_count_o = nfrag_q;
    assign fragsrc_mask_o    = mask_q;
    assign event_open_o      = open_q;

endmodule

// File: tb/tb_turf_event_ctrl_mport.sv
// Bench for turf_event_ctrl_mport: directed command packets with a
// response scoreboard checked by an independent output monitor.
module tb_turf_event_ctrl_mport;

    localparam logic [47:0] MAC = 48'h0211_2233_4455;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [63:0]  s_udphdr_tdata;
    logic         s_udphdr_tvalid;
    logic         s_udphdr_tready;
    logic [63:0]  s_udpdata_tdata;
    logic [7:0]   s_udpdata_tkeep;
    logic         s_udpdata_tlast;
    logic         s_udpdata_tvalid;
    logic         s_udpdata_tready;
    logic [63:0]  m_udphdr_tdata;
    logic         m_udphdr_tvalid;
    logic         m_udphdr_tready;
    logic [63:0]  m_udpdata_tdata;
    logic [7:0]   m_udpdata_tkeep;
    logic         m_udpdata_tlast;
    logic         m_udpdata_tvalid;
    logic         m_udpdata_tready;
    logic [9:0]   nfragment_count_o;
    logic [15:0]  fragsrc_mask_o;
    logic [127:0] event_ip_o;
    logic [63:0]  event_port_o;
    logic [3:0]   event_open_o;

    turf_event_ctrl_mport dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_udphdr_tdata    (s_udphdr_tdata),
        .s_udphdr_tvalid   (s_udphdr_tvalid),
        .s_udphdr_tready   (s_udphdr_tready),
        .s_udpdata_tdata   (s_udpdata_tdata),
        .s_udpdata_tkeep   (s_udpdata_tkeep),
        .s_udpdata_tlast   (s_udpdata_tlast),
        .s_udpdata_tvalid  (s_udpdata_tvalid),
        .s_udpdata_tready  (s_udpdata_tready),
        .m_udphdr_tdata    (m_udphdr_tdata),
        .m_udphdr_tvalid   (m_udphdr_tvalid),
        .m_udphdr_tready   (m_udphdr_tready),
        .m_udpdata_tdata   (m_udpdata_tdata),
        .m_udpdata_tkeep   (m_udpdata_tkeep),
        .m_udpdata_tlast   (m_udpdata_tlast),
        .m_udpdata_tvalid  (m_udpdata_tvalid),
        .m_udpdata_tready  (m_udpdata_tready),
        .my_mac_address    (MAC),
        .nfragment_count_o (nfragment_count_o),
        .fragsrc_mask_o    (fragsrc_mask_o),
        .event_ip_o        (event_ip_o),
        .event_port_o      (event_port_o),
        .event_open_o      (event_open_o)
    );

    always #5 aclk = ~aclk;

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;
    bit rnd   = 1'b0;

    logic [63:0] exp_hdr [$];
    logic [72:0] exp_dat [$];
    logic [63:0] pw [$];
    logic [7:0]  pk [$];
    logic [63:0] pe [$];
    int          beat_cyc [$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Output ready pattern: steady or random per cycle.
    initial begin
        m_udphdr_tready  = 1'b1;
        m_udpdata_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_udphdr_tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_udpdata_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pop and compare on every output handshake.
    logic        stall = 1'b0;
    logic [72:0] stall_v;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (stall) begin
                chk("data_stable",
                    {m_udpdata_tvalid, m_udpdata_tkeep,
                     m_udpdata_tlast, m_udpdata_tdata},
                    {1'b1, stall_v});
            end
            stall   = m_udpdata_tvalid && !m_udpdata_tready;
            stall_v = {m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tdata};
            if (m_udphdr_tvalid && m_udphdr_tready) begin
                if (exp_hdr.size() == 0) begin
                    chk("hdr_unexpected", m_udphdr_tdata, 128'hx);
                end else begin
                    chk("hdr", m_udphdr_tdata, exp_hdr.pop_front());
                end
            end
            if (m_udpdata_tvalid && m_udpdata_tready) begin
                if (exp_dat.size() == 0) begin
                    chk("data_unexpected", m_udpdata_tdata, 128'hx);
                end else begin
                    chk("data", {m_udpdata_tkeep, m_udpdata_tlast,
                                 m_udpdata_tdata}, exp_dat.pop_front());
                end
            end
        end
    end

    task automatic send_hdr(input logic [63:0] h);
        int n = 0;
        s_udphdr_tdata  = h;
        s_udphdr_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_udphdr_tready && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 3000) chk("hdr_in_timeout", 0, 1);
        @(posedge aclk);
        #1;
        s_udphdr_tvalid = 1'b0;
    endtask

    task automatic send_dat(input logic [63:0] w, input logic [7:0] k,
                            input logic l);
        int n = 0;
        s_udpdata_tdata  = w;
        s_udpdata_tkeep  = k;
        s_udpdata_tlast  = l;
        s_udpdata_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_udpdata_tready && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 3000) chk("dat_in_timeout", 0, 1);
        @(posedge aclk);
        #1;
        beat_cyc.push_back(cyc);
        s_udpdata_tvalid = 1'b0;
        s_udpdata_tlast  = 1'b0;
    endtask

    task automatic add(input logic [63:0] w, input logic [63:0] e);
        pw.push_back(w);
        pk.push_back(8'hFF);
        pe.push_back(e);
    endtask

    task automatic run_pkt(input logic [31:0] ip, input logic [15:0] port);
        int n = 0;
        beat_cyc.delete();
        exp_hdr.push_back({ip, port, 16'(8 + 8 * pe.size())});
        foreach (pe[i]) begin
            exp_dat.push_back({8'hFF, 1'(i == pe.size() - 1), pe[i]});
        end
        send_hdr({ip, port, 16'(8 * pw.size())});
        foreach (pw[i]) begin
            send_dat(pw[i], pk[i], 1'(i == pw.size() - 1));
        end
        pw.delete();
        pk.delete();
        pe.delete();
        while ((exp_hdr.size() != 0 || exp_dat.size() != 0) && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        chk("drain", {exp_hdr.size(), exp_dat.size()}, 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_open", event_open_o, 4'b0000);
        chk("rst_ip", event_ip_o, 128'h0);
        chk("rst_port", event_port_o, 64'h0);
        chk("rst_nfrag", nfragment_count_o, 10'd127);
        chk("rst_mask", fragsrc_mask_o, 16'h0000);
        chk("rst_valid", {m_udphdr_tvalid, m_udpdata_tvalid}, 2'b00);
        chk("rst_ready", {s_udphdr_tready, s_udpdata_tready}, 2'b00);
    endtask

    logic [63:0] w;
    int gap;

    initial begin
        aresetn          = 1'b0;
        s_udphdr_tdata   = '0;
        s_udphdr_tvalid  = 1'b0;
        s_udpdata_tdata  = '0;
        s_udpdata_tkeep  = '0;
        s_udpdata_tlast  = 1'b0;
        s_udpdata_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_outs();
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("idle_hdr_ready", s_udphdr_tready, 1'b1);

        // Open ch2
        add(64'h0A00_0001_1388_024F, 64'h0A00_0001_1388_024F);
        run_pkt(32'hC0A8_0164, 16'h0FA0);
        chk("open_ch2", event_open_o, 4'b0100);
        chk("ip_ch2", event_ip_o[95:64], 32'h0A00_0001);
        chk("port_ch2", event_port_o[47:32], 16'd5000);

        // Close ch3 then status: holdoff between the two reads
        add(64'h0000_0000_0000_0343, 64'h0000_0000_0000_0343);
        add(64'h0000_0000_0000_0053, 64'h0053_0000_0000_0004);
        run_pkt(32'hC0A8_0165, 16'h0FA1);
        gap = beat_cyc[1] - beat_cyc[0];
        nchk++;
        if (gap < 33) begin
            nfail++;
            $display("FAIL hold_gap: got %0d cycles expected >= 33", gap);
        end

        // I, R, S
        add(64'h0000_0000_0000_0049, 64'h0049_0211_2233_4455);
        add(64'h0000_0000_0000_0052, 64'h0052_1F9F_0FFF_003F);
        add(64'h0000_0000_0000_0053, 64'h0053_0000_0000_0004);
        run_pkt(32'h0A0B_0C0D, 16'h2222);

        // Close ch2
        add(64'h0000_0000_0000_0243, 64'h0000_0000_0000_0243);
        run_pkt(32'h0A0B_0C0D, 16'h2223);
        chk("close_ch2", event_open_o, 4'b0000);

        // W 2047 bytes field, mask 3F, all closed
        add(64'h07FF_0000_003F_0057, 64'h0057_07F8_0FFF_003F);
        run_pkt(32'h0A0B_0C0E, 16'h3000);
        chk("w_nfrag", nfragment_count_o, 10'd255);
        chk("w_mask", fragsrc_mask_o, 16'h003F);

        // W over limit (mask only), then exactly at limit
        add(64'h1FA0_0000_0015_0057, 64'h0057_07F8_0FFF_0015);
        add(64'h1F9F_0000_003F_0057, 64'h0057_1F98_0FFF_003F);
        run_pkt(32'h0A0B_0C0E, 16'h3001);
        chk("w_lim_nfrag", nfragment_count_o, 10'd1011);

        // Open ch0, W is then refused and reports current values
        add(64'hC0A8_0001_1234_004F, 64'hC0A8_0001_1234_004F);
        add(64'h07FF_0000_000A_0057, 64'h0057_1F98_0FFF_003F);
        run_pkt(32'h0A0B_0C0F, 16'h3002);
        chk("wopen_nfrag", nfragment_count_o, 10'd1011);
        chk("wopen_mask", fragsrc_mask_o, 16'h003F);
        chk("wopen_open", event_open_o, 4'b0001);
        chk("ip_ch0", event_ip_o[31:0], 32'hC0A8_0001);

        // 10 words: 8 executed, last 2 (opens) dumped
        add(64'h0000_0000_0000_0043, 64'h0000_0000_0000_0043);
        for (int i = 1; i < 8; i++) begin
            add({48'h0, 8'(i), 8'h53}, {8'(i), 8'h53, 48'h0});
        end
        pw.push_back(64'h0B00_0001_0007_014F);
        pk.push_back(8'hFF);
        pw.push_back(64'h0B00_0002_0008_014F);
        pk.push_back(8'hFF);
        run_pkt(32'h0102_0304, 16'h4000);
        chk("dump_open", event_open_o, 4'b0000);
        chk("dump_ip1", event_ip_o[63:32], 32'h0);

        // Errors
        add(64'h1234_5678_9ABC_0058, 64'h1234_5678_9ABC_003F);
        add(64'h0C00_0001_0050_074F, 64'h0C00_0001_0050_073F);
        pw.push_back(64'h0D00_0001_0051_014F);
        pk.push_back(8'h0F);
        pe.push_back(64'h0D00_0001_0051_013F);
        run_pkt(32'h0102_0305, 16'h4001);
        chk("err_open", event_open_o, 4'b0000);
        chk("err_ip1", event_ip_o[63:32], 32'h0);
        chk("err_cfg", {nfragment_count_o, fragsrc_mask_o},
            {10'd1011, 16'h003F});

        // Random output backpressure
        rnd = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                case (i % 3)
                    0: add(64'h49, 64'h0049_0211_2233_4455);
                    1: add(64'h52, 64'h0052_1F9F_0FFF_003F);
                    default: add(64'h53, 64'h0053_0000_0000_0000);
                endcase
            end
            run_pkt(32'hAA00_0000 + 32'(r), 16'h5000);
        end
        rnd = 1'b0;
        @(posedge aclk);
        #1;

        // Reset while in holdoff after an open
        send_hdr({32'h0101_0101, 16'h6000, 16'd8});
        send_dat(64'h0E00_0001_0060_014F, 8'hFF, 1'b1);
        repeat (5) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk_reset_outs();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_rst_idle", {s_udphdr_tready, s_udpdata_tready}, 2'b10);

        // Working again from reset configuration
        add(64'h53, 64'h0053_0000_0000_0000);
        add(64'h1FA0_0000_0001_0057, 64'h0057_03F8_0FFF_0001);
        run_pkt(32'h0202_0202, 16'h7000);
        chk("final_mask", fragsrc_mask_o, 16'h0001);

        repeat (20) @(negedge aclk);
        chk("no_extra", {exp_hdr.size(), exp_dat.size()}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
